// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared constants for the data-memory arbiter
package dmem_arbiter_pkg;

    // Requester ids; a single bit is enough for two requesters.
    localparam logic REQ_CORE   = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    localparam int DEFAULT_MAX_HOLD = 8;

    // Hold counter width; the counter saturates at its all-ones value.
    localparam int              HOLD_W   = 8;
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

endpackage

// File: rtl/arb_rdata_reg.sv
// rtl/arb_rdata_reg.sv - per-requester read-return register (rvalid pulse + held rdata)
//
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   load_i     requester had a granted read this cycle
//   rd_i       combinational read data from memory
//   rvalid_o   one-cycle pulse the cycle after a granted read
//   rdata_o    captured read data, held until the next granted read
module arb_rdata_reg #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [DW-1:0] rd_i,
    output logic          rvalid_o,
    output logic [DW-1:0] rdata_o
);

    logic          rvalid_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (load_i) begin
            rdata_d = rd_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= load_i;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data-memory arbiter with lock/hold and read return
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   m0_*                         core load/store requester (req/we/lock/addr/wdata in,
//                                gnt/rvalid/rdata out)
//   m1_*                         program/debug loader requester, same shape as m0_*
//   core_stall                   core is requesting but not granted
//   mem_A, mem_WE, mem_WD        drive the data memory
//   mem_RD                       combinational read data from the data memory
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          core_stall,
    output logic [AW-1:0] mem_A,
    output logic          mem_WE,
    output logic [DW-1:0] mem_WD,
    input  logic [DW-1:0] mem_RD
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    logic              last_q, last_d;
    logic              lock_q, lock_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic grant_any;
    logic gnt_id;
    logic gnt_we;
    logic other_req;

    // Grant decision. rst is folded in so the memory port goes quiet the
    // instant reset asserts, without waiting for a clock edge.
    always_comb begin
        grant_any = 1'b0;
        gnt_id    = last_q;
        if (rst) begin
            unique case ({m1_req, m0_req})
                2'b01: begin
                    grant_any = 1'b1;
                    gnt_id    = REQ_CORE;
                end
                2'b10: begin
                    grant_any = 1'b1;
                    gnt_id    = REQ_LOADER;
                end
                2'b11: begin
                    grant_any = 1'b1;
                    // Locked owner keeps the memory until its hold budget is spent.
                    if (lock_q && (hold_q < MAX_HOLD_C)) begin
                        gnt_id = last_q;
                    end else begin
                        gnt_id = ~last_q;
                    end
                end
                default: begin
                    grant_any = 1'b0;
                end
            endcase
        end
    end

    assign m0_gnt     = grant_any && (gnt_id == REQ_CORE);
    assign m1_gnt     = grant_any && (gnt_id == REQ_LOADER);
    assign core_stall = m0_req && !m0_gnt;

    assign gnt_we    = (gnt_id == REQ_LOADER) ? m1_we : m0_we;
    assign other_req = (gnt_id == REQ_LOADER) ? m0_req : m1_req;

    assign mem_A  = !grant_any ? '0 : ((gnt_id == REQ_LOADER) ? m1_addr : m0_addr);
    assign mem_WD = !grant_any ? '0 : ((gnt_id == REQ_LOADER) ? m1_wdata : m0_wdata);
    assign mem_WE = grant_any && gnt_we;

    always_comb begin
        last_d = last_q;
        lock_d = 1'b0;
        hold_d = '0;
        if (grant_any) begin
            last_d = gnt_id;
            lock_d = (gnt_id == REQ_LOADER) ? m1_lock : m0_lock;
            // Only repeat grants taken while the other side waited count
            // toward the hold budget; uncontested bursts leave it at zero.
            if ((gnt_id == last_q) && other_req) begin
                hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
            end
        end
    end

    // last resets to the loader so the first tie after reset goes to the core.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= REQ_LOADER;
            lock_q <= 1'b0;
            hold_q <= '0;
        end else begin
            last_q <= last_d;
            lock_q <= lock_d;
            hold_q <= hold_d;
        end
    end

    arb_rdata_reg #(.DW(DW)) u_rdata_m0 (
        .clk      (clk),
        .rst      (rst),
        .load_i   (m0_gnt && !m0_we),
        .rd_i     (mem_RD),
        .rvalid_o (m0_rvalid),
        .rdata_o  (m0_rdata)
    );

    arb_rdata_reg #(.DW(DW)) u_rdata_m1 (
        .clk      (clk),
        .rst      (rst),
        .load_i   (m1_gnt && !m1_we),
        .rd_i     (mem_RD),
        .rvalid_o (m1_rvalid),
        .rdata_o  (m1_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          m0_req, m0_we, m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req, m1_we, m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          core_stall;
    logic [AW-1:0] mem_A;
    logic          mem_WE;
    logic [DW-1:0] mem_WD;
    logic [DW-1:0] mem_RD;

    int checks;
    int errors;

    logic [DW-1:0] mem [0:255];

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_req     (m0_req),
        .m0_we      (m0_we),
        .m0_lock    (m0_lock),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_gnt     (m0_gnt),
        .m0_rvalid  (m0_rvalid),
        .m0_rdata   (m0_rdata),
        .m1_req     (m1_req),
        .m1_we      (m1_we),
        .m1_lock    (m1_lock),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_gnt     (m1_gnt),
        .m1_rvalid  (m1_rvalid),
        .m1_rdata   (m1_rdata),
        .core_stall (core_stall),
        .mem_A      (mem_A),
        .mem_WE     (mem_WE),
        .mem_WD     (mem_WD),
        .mem_RD     (mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_RD = mem[mem_A[7:0]];

    always @(posedge clk) begin
        if (mem_WE) mem[mem_A[7:0]] <= mem_WD;
    end

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        m1_req = 1; m1_we = 1; m1_addr = 32'h8; m1_wdata = 32'h1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m1_gnt !== 1'b0 || mem_WE !== 1'b0 || mem_A !== '0 || mem_WD !== '0) begin
            errors++;
            $display("FAIL reset_comb gnt=%b we=%b A=%h WD=%h required 0/0/0/0", m1_gnt, mem_WE, mem_A, mem_WD);
        end
        checks++;
        if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m0_rdata !== '0 || m1_rdata !== '0) begin
            errors++;
            $display("FAIL reset_regs rv0=%b rv1=%b rd0=%h rd1=%h required all 0", m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
        end
        checks++;
        if (mem[8] !== 32'h0) begin
            errors++;
            $display("FAIL reset_nowrite mem[8]=%h required 0", mem[8]);
        end
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_round_robin();
        logic exp_m1 [4];
        exp_m1[0] = 0; exp_m1[1] = 1; exp_m1[2] = 0; exp_m1[3] = 1;
        @(negedge clk);
        m0_req = 1; m0_addr = 32'h11;
        m1_req = 1; m1_addr = 32'h12;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (m0_gnt !== !exp_m1[i] || m1_gnt !== exp_m1[i] || core_stall !== exp_m1[i]) begin
                errors++;
                $display("FAIL rr_cycle%0d gnt0=%b gnt1=%b stall=%b required %b/%b/%b",
                         i, m0_gnt, m1_gnt, core_stall, !exp_m1[i], exp_m1[i], exp_m1[i]);
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_read();
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        #1;
        checks++;
        if (m0_gnt !== 1'b1 || mem_A !== 32'h10 || mem_WE !== 1'b0 || core_stall !== 1'b0) begin
            errors++;
            $display("FAIL read_grant gnt=%b A=%h we=%b stall=%b required 1/10/0/0", m0_gnt, mem_A, mem_WE, core_stall);
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL read_return rv0=%b rd0=%h rv1=%b required 1/deadbeef/0", m0_rvalid, m0_rdata, m1_rvalid);
        end
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL read_pulse rv0=%b rd0=%h required 0/deadbeef", m0_rvalid, m0_rdata);
        end
    endtask

    // Core was the last owner, so the loader wins the first contest and then
    // holds for MAX_HOLD more cycles before the core gets its turn.
    task automatic test_lock_burst();
        logic exp_m1 [5];
        exp_m1[0] = 1; exp_m1[1] = 1; exp_m1[2] = 1; exp_m1[3] = 1; exp_m1[4] = 0;
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 32'h40;
        for (int i = 0; i < 5; i++) begin
            m1_wdata = 32'h100 + i;
            #1;
            checks++;
            if (m1_gnt !== exp_m1[i] || m0_gnt !== !exp_m1[i] || core_stall !== exp_m1[i]) begin
                errors++;
                $display("FAIL burst_cycle%0d gnt0=%b gnt1=%b stall=%b required %b/%b/%b",
                         i, m0_gnt, m1_gnt, core_stall, !exp_m1[i], exp_m1[i], exp_m1[i]);
            end
            @(negedge clk);
        end
        idle_inputs();
        checks++;
        if (mem[8'h40] !== 32'h103) begin
            errors++;
            $display("FAIL burst_data mem[40]=%h required 00000103", mem[8'h40]);
        end
    endtask

    task automatic test_write_then_read();
        @(negedge clk);
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'hA5A5A5A5;
        #1;
        checks++;
        if (m1_gnt !== 1'b1 || mem_WE !== 1'b1 || mem_A !== 32'h20 || mem_WD !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL wr_grant gnt1=%b we=%b A=%h WD=%h required 1/1/20/a5a5a5a5", m1_gnt, mem_WE, mem_A, mem_WD);
        end
        @(negedge clk);
        idle_inputs();
        m0_req = 1; m0_addr = 32'h20;
        #1;
        checks++;
        if (m0_gnt !== 1'b1 || mem_WE !== 1'b0 || m1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_after_wr gnt0=%b we=%b rv1=%b required 1/0/0", m0_gnt, mem_WE, m1_rvalid);
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL wr_rd_data rv0=%b rd0=%h required 1/a5a5a5a5", m0_rvalid, m0_rdata);
        end
    endtask

    // An uncontested locked burst must not consume hold budget: once the core
    // joins, the loader still gets MAX_HOLD grants (hold 0,1,2) before yielding.
    task automatic test_lock_alone();
        logic exp_m1 [4];
        int bad;
        exp_m1[0] = 1; exp_m1[1] = 1; exp_m1[2] = 1; exp_m1[3] = 0;
        bad = 0;
        @(negedge clk);
        m1_req = 1; m1_we = 0; m1_lock = 1; m1_addr = 32'h50;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (m1_gnt !== 1'b1 || core_stall !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL lock_alone bad_cycles=%0d required 0", bad);
        end
        m0_req = 1; m0_addr = 32'h10;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (m1_gnt !== exp_m1[i] || m0_gnt !== !exp_m1[i]) begin
                errors++;
                $display("FAIL lock_join%0d gnt0=%b gnt1=%b required %b/%b",
                         i, m0_gnt, m1_gnt, !exp_m1[i], exp_m1[i]);
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        m0_req = 1; m0_addr = 32'h10;
        @(negedge clk);
        idle_inputs();
        m1_req = 1; m1_we = 1; m1_addr = 32'h30; m1_wdata = 32'h12345678;
        #1;
        checks++;
        if (m1_gnt !== 1'b1 || mem_WE !== 1'b1 || m0_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre gnt1=%b we=%b rv0=%b required 1/1/1", m1_gnt, mem_WE, m0_rvalid);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (m1_gnt !== 1'b0 || mem_WE !== 1'b0 || mem_A !== '0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL arst_now gnt1=%b we=%b A=%h rv0=%b rv1=%b required 0/0/0/0/0",
                     m1_gnt, mem_WE, mem_A, m0_rvalid, m1_rvalid);
        end
        @(negedge clk);
        checks++;
        if (mem[8'h30] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL arst_mem mem[30]=%h required 0badf00d", mem[8'h30]);
        end
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        m0_req = 1; m0_addr = 32'h10;
        m1_req = 1; m1_addr = 32'h30;
        #1;
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL arst_tie gnt0=%b gnt1=%b required 1/0", m0_gnt, m1_gnt);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h30] = 32'h0BADF00D;
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_round_robin();
        test_read();
        test_lock_burst();
        test_write_then_read();
        test_lock_alone();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    always @(negedge clk) begin
        if (m0_gnt === 1'b1 && m1_gnt === 1'b1) begin
            errors++;
            $display("FAIL both_gnt gnt0=%b gnt1=%b required at most one", m0_gnt, m1_gnt);
        end
    end

endmodule
